loopback_checker: RTL

LOOPBACK_CHECKER -- requirements
Module: loopback_checker

---
 rtl/loopback_checker.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/loopback_checker.sv
// loopback_checker: counter/PRBS7 pattern generator with a self-synchronising
// loopback checker. Define LOOPBACK_CHECKER_PRBS_EN to build in PRBS7 support.
module loopback_checker #(
    parameter int DATA_W     = 8,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic                      clr_err,
    output logic [DATA_W-1:0]         tx_data,
    input  logic [DATA_W-1:0]         rx_data,
    input  logic                      rx_valid,
    output logic                      locked,
    output logic [$clog2(DATA_W)-1:0] slip,
    output logic                      err_pulse,
    output logic [ERR_W-1:0]          err_cnt
);
    localparam int SLIP_W = $clog2(DATA_W);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [SLIP_W-1:0] SLIP_MAX  = SLIP_W'(DATA_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        SETTLE,
        SEARCH,
        LOCKED
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   gen_cnt;
    logic [DATA_W-1:0]   prev;
    logic [DATA_W-1:0]   aligned;
    logic [DATA_W-1:0]   expect_w;
    logic [2*DATA_W-1:0] rot_w;
    logic [GOOD_W-1:0]   good;
    logic [BAD_W-1:0]    bad;
    logic                match;
    logic                reseed;
    logic                cnt_run;
    logic                err_ev;

    // Rotate left by slip: top half of the doubled word shifted left.
    assign rot_w   = {rx_data, rx_data} << slip;
    assign aligned = rot_w[2*DATA_W-1:DATA_W];

`ifdef LOOPBACK_CHECKER_PRBS_EN
    logic [DATA_W-1:0] gen_prbs;
    logic              mode_q;
    logic              armed;

    // x^7+x^6+1, MSB first; next word depends only on the last 7 bits.
    function automatic logic [DATA_W-1:0] prbs_next(
        input logic [DATA_W-1:0] w
    );
        logic [6:0]        h;
        logic [DATA_W-1:0] o;
        h = w[6:0];
        o = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            o[i] = h[6] ^ h[5];
            h    = {h[5:0], o[i]};
        end
        return o;
    endfunction

    // Remember the mode; armed blocks a false change on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            mode_q <= mode;
            armed  <= 1'b1;
        end
    end

    assign reseed   = armed && (mode != mode_q);
    assign cnt_run  = !mode;
    assign tx_data  = mode ? gen_prbs : gen_cnt;
    assign expect_w = mode ? prbs_next(prev) : prev + 1'b1;
    assign match    = (aligned == expect_w) && !(mode && aligned == '0);

    // PRBS7 generator; held at its seed while the counter is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_prbs <= '1;
        end else if (reseed) begin
            gen_prbs <= '1;
        end else if (mode) begin
            gen_prbs <= prbs_next(gen_prbs);
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign reseed      = 1'b0;
    assign cnt_run     = 1'b1;
    assign tx_data     = gen_cnt;
    assign expect_w    = prev + 1'b1;
    assign match       = (aligned == expect_w);
`endif

    // Counter generator; wraps naturally at 2^DATA_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_cnt <= '0;
        end else if (reseed) begin
            gen_cnt <= '0;
        end else if (cnt_run) begin
            gen_cnt <= gen_cnt + 1'b1;
        end
    end

    assign err_ev = !reseed && rx_valid && (state == LOCKED) && !match;

    // Alignment FSM with registered lock flag, error strobe and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SETTLE;
            prev      <= '0;
            good      <= '0;
            bad       <= '0;
            slip      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= err_ev;
            if (clr_err) begin
                err_cnt <= '0;
            end else if (err_ev && !(&err_cnt)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (reseed) begin
                state  <= SETTLE;
                locked <= 1'b0;
            end else if (rx_valid) begin
                prev <= aligned;
                unique case (state)
                    SETTLE: begin
                        good  <= '0;
                        bad   <= '0;
                        state <= SEARCH;
                    end
                    SEARCH: begin
                        if (match) begin
                            good <= good + 1'b1;
                            if (good == GOOD_LAST) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            slip  <= (slip == SLIP_MAX) ? '0 : slip + 1'b1;
                            good  <= '0;
                            state <= SETTLE;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            bad <= '0;
                        end else begin
                            bad <= bad + 1'b1;
                            if (bad == BAD_LAST) begin
                                state  <= SETTLE;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= SETTLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
